spi_window_receiver: RTL and testbench

Parametrised successor to the SPI pixel-column front end. It receives column words over SPI and rebuilds a KERNEL x KERNEL pixel window with an in-order column shift register. It tracks image coordinates with correct wrap-around and delivers windows to the edge-detection datapath over a valid/ready handshake with overrun reporting. It runs entirely on mainClk: sclk, sdi and ncs are synchronised and oversampled, with no second clock domain.

---
 rtl/spi_window_pkg.sv | 26 ++
 rtl/spi_sync_receiver.sv | 93 +++++++++
 rtl/spi_window_receiver.sv | 163 ++++++++++++++++
 tb/tb_spi_window_receiver.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_window_pkg.sv
// Shared types and defaults for the SPI window receiver.
//   rxState_t   : receiver FSM states
//   DEF_*       : default parameter values
//   win_offset  : bit offset of window element [r][c] in the flattened window
package spi_window_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMPLETE
   } rxState_t;

   localparam int unsigned DEF_PIXEL_BITS = 4;
   localparam int unsigned DEF_KERNEL     = 3;
   localparam int unsigned DEF_MSG_BITS   = 16;
   localparam int unsigned DEF_IMG_WIDTH  = 320;
   localparam int unsigned DEF_IMG_HEIGHT = 240;

   function automatic int unsigned win_offset(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned kernel,
                                              input int unsigned pixelBits);
      return (r * kernel + c) * pixelBits;
   endfunction

endpackage

// File: rtl/spi_sync_receiver.sv
// Oversampling SPI receiver running on the system clock.
//   clk_i, rst_i : system clock, async active-high reset
//   sclk_i, sdi_i, ncs_i : raw SPI inputs (2-flop synchronised here)
//   colWord_o    : low COL_BITS bits of the last complete message
//   colValid_o   : one-cycle pulse when colWord_o is updated
module spi_sync_receiver
   import spi_window_pkg::*;
#(
   parameter int unsigned MSG_BITS = DEF_MSG_BITS,
   parameter int unsigned COL_BITS = DEF_KERNEL * DEF_PIXEL_BITS
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sclk_i,
   input  logic                sdi_i,
   input  logic                ncs_i,
   output logic [COL_BITS-1:0] colWord_o,
   output logic                colValid_o
);

   localparam int unsigned         CNT_BITS = $clog2(MSG_BITS + 1);
   localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(MSG_BITS - 1);

   logic [1:0]          sclkSync_q;
   logic [1:0]          sdiSync_q;
   logic [1:0]          ncsSync_q;
   logic                sclkPrev_q;
   rxState_t            state_q;
   logic [CNT_BITS-1:0] bitCount_q;
   logic [COL_BITS-1:0] shift_q;
   logic [COL_BITS-1:0] colWord_q;
   logic                colValid_q;

   logic sclkRise;
   logic ncsLow;

   assign sclkRise   = sclkSync_q[1] & ~sclkPrev_q;
   assign ncsLow     = ~ncsSync_q[1];
   assign colWord_o  = colWord_q;
   assign colValid_o = colValid_q;

   // Only the low COL_BITS of a message are kept; earlier (higher) bits
   // simply fall off the end of the shift register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclkSync_q <= '0;
         sdiSync_q  <= '0;
         ncsSync_q  <= '0;
         sclkPrev_q <= 1'b0;
         state_q    <= IDLE;
         bitCount_q <= '0;
         shift_q    <= '0;
         colWord_q  <= '0;
         colValid_q <= 1'b0;
      end else begin
         sclkSync_q <= {sclkSync_q[0], sclk_i};
         sdiSync_q  <= {sdiSync_q[0], sdi_i};
         ncsSync_q  <= {ncsSync_q[0], ncs_i};
         sclkPrev_q <= sclkSync_q[1];
         colValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               bitCount_q <= '0;
               if (ncsLow) begin
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (!ncsLow) begin
                  bitCount_q <= '0;
                  state_q    <= IDLE;
               end else if (sclkRise) begin
                  shift_q    <= {shift_q[COL_BITS-2:0], sdiSync_q[1]};
                  bitCount_q <= bitCount_q + CNT_BITS'(1);
                  if (bitCount_q == LAST_BIT) begin
                     state_q <= COMPLETE;
                  end
               end
            end
            COMPLETE: begin
               colValid_q <= 1'b1;
               colWord_q  <= shift_q;
               bitCount_q <= '0;
               state_q    <= ncsLow ? SHIFT : IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/spi_window_receiver.sv
// Rebuilds a KERNEL x KERNEL pixel window from SPI column messages and hands
// it to the downstream datapath over valid/ready.
//   mainClk, reset        : system clock, async active-high reset
//   sclk, sdi, ncs        : SPI slave inputs (oversampled on mainClk)
//   windowData            : element [r][c] at (r*KERNEL+c)*PIXEL_BITS, c=0 oldest
//   windowValid/Ready     : output handshake
//   windowX, windowY      : left-edge column and row of the window
//   rowStart, frameStart  : window at x==0 / at (0,0)
//   overrun, clearOverrun : sticky lost-window flag and its clear
module spi_window_receiver
   import spi_window_pkg::*;
#(
   parameter int unsigned PIXEL_BITS = DEF_PIXEL_BITS,
   parameter int unsigned KERNEL     = DEF_KERNEL,
   parameter int unsigned MSG_BITS   = DEF_MSG_BITS,
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int unsigned X_BITS     = $clog2(IMG_WIDTH),
   parameter int unsigned Y_BITS     = $clog2(IMG_HEIGHT)
) (
   input  logic                                 mainClk,
   input  logic                                 reset,
   input  logic                                 sclk,
   input  logic                                 sdi,
   input  logic                                 ncs,
   output logic [KERNEL*KERNEL*PIXEL_BITS-1:0]  windowData,
   output logic                                 windowValid,
   input  logic                                 windowReady,
   output logic [X_BITS-1:0]                    windowX,
   output logic [Y_BITS-1:0]                    windowY,
   output logic                                 rowStart,
   output logic                                 frameStart,
   output logic                                 overrun,
   input  logic                                 clearOverrun
);

   localparam int unsigned          COL_BITS  = KERNEL * PIXEL_BITS;
   localparam int unsigned          WIN_BITS  = KERNEL * COL_BITS;
   localparam int unsigned          FILL_BITS = $clog2(KERNEL + 1);
   localparam logic [X_BITS-1:0]    X_LAST    = X_BITS'(IMG_WIDTH - 1);
   localparam logic [Y_BITS-1:0]    Y_LAST    = Y_BITS'(IMG_HEIGHT - 1);
   localparam logic [X_BITS-1:0]    X_BACK    = X_BITS'(KERNEL - 1);
   localparam logic [FILL_BITS-1:0] FILL_FULL = FILL_BITS'(KERNEL);

   logic [COL_BITS-1:0]  colWord;
   logic                 colValid;

   logic [WIN_BITS-1:0]  win_q, win_d;
   logic [X_BITS-1:0]    colX_q;
   logic [Y_BITS-1:0]    colY_q;
   logic [FILL_BITS-1:0] fill_q, fill_d;
   logic                 loadPending_q;
   logic [X_BITS-1:0]    pendX_q;
   logic [Y_BITS-1:0]    pendY_q;

   logic [WIN_BITS-1:0]  outData_q;
   logic                 outValid_q;
   logic [X_BITS-1:0]    outX_q;
   logic [Y_BITS-1:0]    outY_q;
   logic                 rowStart_q;
   logic                 frameStart_q;
   logic                 overrun_q;

   spi_sync_receiver #(
      .MSG_BITS (MSG_BITS),
      .COL_BITS (COL_BITS)
   ) u_rx (
      .clk_i      (mainClk),
      .rst_i      (reset),
      .sclk_i     (sclk),
      .sdi_i      (sdi),
      .ncs_i      (ncs),
      .colWord_o  (colWord),
      .colValid_o (colValid)
   );

   // Column shift: each row moves one place toward c=0, new pixel enters at
   // c=KERNEL-1. Row 0 is the most significant pixel field of the column word.
   always_comb begin
      win_d = win_q;
      for (int unsigned r = 0; r < KERNEL; r++) begin
         for (int unsigned c = 0; c < KERNEL - 1; c++) begin
            win_d[win_offset(r, c, KERNEL, PIXEL_BITS) +: PIXEL_BITS] =
               win_q[win_offset(r, c + 1, KERNEL, PIXEL_BITS) +: PIXEL_BITS];
         end
         win_d[win_offset(r, KERNEL - 1, KERNEL, PIXEL_BITS) +: PIXEL_BITS] =
            colWord[(KERNEL - 1 - r) * PIXEL_BITS +: PIXEL_BITS];
      end
   end

   // Fill restarts at the first column of every row so windows never span rows.
   always_comb begin
      fill_d = fill_q;
      if (colX_q == '0) begin
         fill_d = FILL_BITS'(1);
      end else if (fill_q != FILL_FULL) begin
         fill_d = fill_q + FILL_BITS'(1);
      end
   end

   always_ff @(posedge mainClk or posedge reset) begin
      if (reset) begin
         win_q         <= '0;
         colX_q        <= '0;
         colY_q        <= '0;
         fill_q        <= '0;
         loadPending_q <= 1'b0;
         pendX_q       <= '0;
         pendY_q       <= '0;
         outData_q     <= '0;
         outValid_q    <= 1'b0;
         outX_q        <= '0;
         outY_q        <= '0;
         rowStart_q    <= 1'b0;
         frameStart_q  <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         loadPending_q <= 1'b0;
         if (colValid) begin
            win_q         <= win_d;
            fill_q        <= fill_d;
            pendX_q       <= colX_q - X_BACK;
            pendY_q       <= colY_q;
            loadPending_q <= (fill_d == FILL_FULL);
            if (colX_q == X_LAST) begin
               colX_q <= '0;
               colY_q <= (colY_q == Y_LAST) ? '0 : colY_q + Y_BITS'(1);
            end else begin
               colX_q <= colX_q + X_BITS'(1);
            end
         end

         // Coordinates of the completed column are held in pend*_q because
         // colX_q/colY_q have already advanced by the time the output loads.
         if (loadPending_q) begin
            outData_q    <= win_q;
            outX_q       <= pendX_q;
            outY_q       <= pendY_q;
            rowStart_q   <= (pendX_q == '0);
            frameStart_q <= (pendX_q == '0) && (pendY_q == '0);
            outValid_q   <= 1'b1;
         end else if (outValid_q && windowReady) begin
            outValid_q <= 1'b0;
         end

         // Set has priority over clear.
         if (loadPending_q && outValid_q && !windowReady) begin
            overrun_q <= 1'b1;
         end else if (clearOverrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign windowData  = outData_q;
   assign windowValid = outValid_q;
   assign windowX     = outX_q;
   assign windowY     = outY_q;
   assign rowStart    = rowStart_q;
   assign frameStart  = frameStart_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_window_receiver.sv
// Scoreboard bench for spi_window_receiver: a full-size instance plus a
// 5x3-image instance sharing the SPI lines so frame wrap can be reached quickly.
module tb_spi_window_receiver;

   logic mainClk = 1'b0;
   logic reset = 1'b1;
   logic sclk = 1'b0;
   logic sdi = 1'b0;
   logic ncs = 1'b1;
   logic windowReady = 1'b0;
   logic clearOverrun = 1'b0;

   logic [35:0] windowData;
   logic        windowValid;
   logic [8:0]  windowX;
   logic [7:0]  windowY;
   logic        rowStart, frameStart, overrun;

   logic [35:0] sData;
   logic        sValid;
   logic [2:0]  sX;
   logic [1:0]  sY;
   logic        sRow, sFrame, sOvr;

   spi_window_receiver dut (
      .mainClk(mainClk), .reset(reset), .sclk(sclk), .sdi(sdi), .ncs(ncs),
      .windowData(windowData), .windowValid(windowValid), .windowReady(windowReady),
      .windowX(windowX), .windowY(windowY), .rowStart(rowStart), .frameStart(frameStart),
      .overrun(overrun), .clearOverrun(clearOverrun)
   );

   spi_window_receiver #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_small (
      .mainClk(mainClk), .reset(reset), .sclk(sclk), .sdi(sdi), .ncs(ncs),
      .windowData(sData), .windowValid(sValid), .windowReady(1'b1),
      .windowX(sX), .windowY(sY), .rowStart(sRow), .frameStart(sFrame),
      .overrun(sOvr), .clearOverrun(1'b0)
   );

   always #5 mainClk = ~mainClk;

   int cyc = 0;
   always @(posedge mainClk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int lastRise = 0;

   typedef struct {
      logic [35:0] data;
      int          x;
      int          y;
      bit          rs;
      bit          fs;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   // Reference model state, one set per instance.
   logic [3:0] mw [2][3][3];
   int mx [2];
   int my [2];
   int mf [2];
   int imgW [2] = '{320, 5};
   int imgH [2] = '{240, 3};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int id = 0; id < 2; id++) begin
         mx[id] = 0; my[id] = 0; mf[id] = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               mw[id][r][c] = 4'h0;
      end
   endtask

   task automatic model_col(input int id, input logic [15:0] w, output bit got, output exp_t e);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 2; c++) mw[id][r][c] = mw[id][r][c+1];
         mw[id][r][2] = w[(2-r)*4 +: 4];
      end
      e.data = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            e.data[(r*3+c)*4 +: 4] = mw[id][r][c];
      if (mx[id] == 0) mf[id] = 1;
      else if (mf[id] < 3) mf[id]++;
      got   = (mf[id] == 3);
      e.x   = mx[id] - 2;
      e.y   = my[id];
      e.rs  = (e.x == 0);
      e.fs  = (e.x == 0) && (e.y == 0);
      e.cyc = -1;
      if (mx[id] == imgW[id] - 1) begin
         mx[id] = 0;
         my[id] = (my[id] == imgH[id] - 1) ? 0 : my[id] + 1;
      end else begin
         mx[id]++;
      end
   endtask

   // mode 0: model only, 1: push model window, 2: push hand entry, 3: hand entry + latency
   task automatic col_hook(input logic [15:0] w, input int mode, input exp_t hand);
      bit   got;
      exp_t e;
      exp_t h;
      model_col(0, w, got, e);
      if (mode == 1 && got) q0.push_back(e);
      if (mode >= 2) begin
         h = hand;
         h.cyc = (mode == 3) ? lastRise + 6 : -1;
         q0.push_back(h);
      end
      model_col(1, w, got, e);
      if (got) q1.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge mainClk);
         #2;
      end
   endtask

   task automatic spi_msg(input logic [15:0] w, input int nbits, input int mode, input exp_t hand);
      if (ncs) begin
         ncs = 1'b0;
         tick(4);
      end
      for (int i = 0; i < nbits; i++) begin
         sdi = w[15-i];
         tick(2);
         sclk = 1'b1;
         if (i == nbits - 1 && nbits == 16) begin
            lastRise = cyc;
            col_hook(w, mode, hand);
         end
         tick(2);
         sclk = 1'b0;
      end
   endtask

   task automatic ncs_hi();
      tick(2);
      ncs = 1'b1;
      tick(8);
   endtask

   task automatic do_reset();
      reset = 1'b1; ncs = 1'b1; sclk = 1'b0; sdi = 1'b0;
      tick(3);
      reset = 1'b0;
      model_reset();
      tick(3);
   endtask

   always @(negedge mainClk) begin
      if (windowValid === 1'b1 && windowReady === 1'b1) begin
         if (q0.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_window: x=%0d y=%0d data=0x%0h, expected no window", windowX, windowY, windowData);
         end else begin
            e0 = q0.pop_front();
            chk("data", windowData, e0.data);
            chk("windowX", 64'(windowX), 64'(e0.x));
            chk("windowY", 64'(windowY), 64'(e0.y));
            chk("rowStart", rowStart, e0.rs);
            chk("frameStart", frameStart, e0.fs);
            if (e0.cyc >= 0) chk("latency_cycle", 64'(cyc), 64'(e0.cyc));
         end
      end
   end

   always @(negedge mainClk) begin
      if (sValid === 1'b1) begin
         if (q1.size() == 0) begin
            tests++; fails++;
            $display("FAIL small_unexpected_window: x=%0d y=%0d, expected no window", sX, sY);
         end else begin
            e1 = q1.pop_front();
            chk("small_data", sData, e1.data);
            chk("small_windowX", 64'(sX), 64'(e1.x));
            chk("small_windowY", 64'(sY), 64'(e1.y));
            chk("small_rowStart", sRow, e1.rs);
            chk("small_frameStart", sFrame, e1.fs);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      exp_t none;
      exp_t h;
      int   waitCnt;
      none = '{36'h0, 0, 0, 1'b0, 1'b0, -1};

      model_reset();
      tick(3);
      reset = 1'b0;
      tick(3);

      // Three columns -> first window at (0,0), with latency check.
      windowReady = 1'b1;
      spi_msg(16'h0123, 16, 1, none);
      spi_msg(16'h0456, 16, 1, none);
      h = '{36'h963852741, 0, 0, 1'b1, 1'b1, -1};
      spi_msg(16'h0789, 16, 3, h);
      ncs_hi();

      // Aborted 9-bit message must be discarded.
      do_reset();
      spi_msg(16'hFFFF, 9, 0, none);
      ncs_hi();
      spi_msg(16'h0ABC, 16, 1, none);
      spi_msg(16'h0DEF, 16, 1, none);
      h = '{36'h3FC2EB1DA, 0, 0, 1'b1, 1'b1, -1};
      spi_msg(16'h0123, 16, 2, h);
      ncs_hi();

      // Overrun with windowReady held low; latest window wins.
      do_reset();
      windowReady = 1'b0;
      spi_msg(16'h0012, 16, 0, none);
      spi_msg(16'h0123, 16, 0, none);
      spi_msg(16'h0234, 16, 0, none);
      spi_msg(16'h0345, 16, 0, none);
      h = '{36'h654543432, 2, 0, 1'b0, 1'b0, -1};
      spi_msg(16'h0456, 16, 2, h);
      tick(8);
      chk("overrun_set", overrun, 1'b1);
      chk("valid_held", windowValid, 1'b1);
      windowReady = 1'b1;
      tick(1);
      windowReady = 1'b0;
      tick(1);
      chk("valid_cleared_after_accept", windowValid, 1'b0);
      clearOverrun = 1'b1;
      tick(1);
      clearOverrun = 1'b0;
      tick(1);
      chk("overrun_clear", overrun, 1'b0);
      spi_msg(16'h0567, 16, 0, none);
      spi_msg(16'h0678, 16, 1, none);
      waitCnt = 0;
      while (cyc < lastRise + 5 && waitCnt < 20) begin
         tick(1);
         waitCnt++;
      end
      if (waitCnt >= 20) begin
         tests++; fails++;
         $display("FAIL load_edge_wait: cycle %0d, expected to reach %0d", cyc, lastRise + 5);
      end
      clearOverrun = 1'b1;
      tick(1);
      clearOverrun = 1'b0;
      tick(1);
      chk("overrun_set_wins", overrun, 1'b1);
      clearOverrun = 1'b1;
      tick(1);
      clearOverrun = 1'b0;
      tick(1);
      chk("overrun_clear2", overrun, 1'b0);
      windowReady = 1'b1;
      tick(1);
      windowReady = 1'b0;

      // Reset mid-message while a window is pending and overrun is set.
      spi_msg(16'h0789, 16, 0, none);
      spi_msg(16'h089A, 16, 0, none);
      tick(8);
      chk("pre_reset_overrun", overrun, 1'b1);
      spi_msg(16'h0ABC, 8, 0, none);
      reset = 1'b1; ncs = 1'b1; sclk = 1'b0; sdi = 1'b0;
      tick(3);
      reset = 1'b0;
      model_reset();
      tick(3);
      chk("rst_windowValid", windowValid, 1'b0);
      chk("rst_windowData", windowData, 36'h0);
      chk("rst_windowX", 64'(windowX), 64'h0);
      chk("rst_windowY", 64'(windowY), 64'h0);
      chk("rst_rowStart", rowStart, 1'b0);
      chk("rst_frameStart", frameStart, 1'b0);
      chk("rst_overrun", overrun, 1'b0);

      // Full row plus row wrap on the 320-wide instance.
      windowReady = 1'b1;
      for (int i = 0; i < 323; i++) begin
         spi_msg({4'hA, 12'(i * 37 + 5)}, 16, 1, none);
      end
      ncs_hi();

      // Frame wrap on the 5x3 instance.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         spi_msg({4'h5, 12'(i * 91 + 3)}, 16, 1, none);
      end
      ncs_hi();
      tick(10);

      chk("queue0_drained", 64'(q0.size()), 64'h0);
      chk("queue1_drained", 64'(q1.size()), 64'h0);
      chk("small_overrun", sOvr, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
